code_loader: RTL and testbench

CODE_LOADER -- requirements
Module: code_loader

---
 rtl/code_loader_pkg.sv | 26 ++
 rtl/code_loader_word_assembler.sv | 30 +++
 rtl/code_loader.sv | 129 ++++++++++++
 tb/tb_code_loader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_loader_pkg.sv
// Shared definitions for the serial code loader: FSM states and the stream word geometry.
package code_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    B0,
    B1,
    B2,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 3;
  localparam int unsigned ASM_WORD_BITS  = 18;

  typedef logic [15:0] count_t;

  // States in which a stream byte may be taken.
  function automatic logic accepts_byte(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == B0) || (s == B1) || (s == B2);
  endfunction

endpackage

// File: rtl/code_loader_word_assembler.sv
// Collects the low bytes of a code word and checks the third byte, which carries
// only the two most-significant bits of the 18-bit word.
module word_assembler
  import code_loader_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     shift,
  input  logic [7:0]               data,
  output logic [ASM_WORD_BITS-1:0] word,
  output logic                     legal
);

  localparam int unsigned STAGED_BITS = (BYTES_PER_WORD - 1) * 8;

  logic [STAGED_BITS-1:0] staged;

  // Bytes arrive LSB first, so each new byte enters at the top and drifts down.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      staged <= '0;
    end else if (shift) begin
      staged <= {data, staged[STAGED_BITS-1:8]};
    end
  end

  assign legal = (data[7:2] == '0);
  assign word  = {data[1:0], staged};

endmodule

// File: rtl/code_loader.sv
// Loads a length-prefixed byte stream of 18-bit code words into code memory while
// holding the processor in reset; a malformed or oversized stream aborts the session.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 code_we,
  output logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_din,
  output logic                 processor_reset,
  output logic                 busy,
  output logic                 error
);

  state_t state, state_next;

  count_t                   n;
  count_t                   counter;
  logic   [7:0]             len_lo;
  logic                     accept;
  count_t                   len_rx;
  logic   [16:0]            count_inc;
  logic                     more_words;
  logic                     len_too_big;
  logic [ASM_WORD_BITS-1:0] word;
  logic                     legal;

  assign rx_ready    = accepts_byte(state);
  assign accept      = rx_valid && rx_ready;
  assign len_rx      = {rx_data, len_lo};
  assign count_inc   = {1'b0, counter} + 17'd1;
  assign more_words  = count_inc < {1'b0, n};
  assign len_too_big = {16'd0, len_rx} > MEM_SIZE;

  assign code_we = (state == WRITE);
  assign busy    = (state != IDLE);

  word_assembler u_asm (
    .clock (clock),
    .reset (reset),
    .shift (accept && ((state == B0) || (state == B1))),
    .data  (rx_data),
    .word  (word),
    .legal (legal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (load_start) state_next = LEN_LO;
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_rx == '0) begin
            state_next = DONE;
          end else if (len_too_big) begin
            state_next = ERR;
          end else begin
            state_next = B0;
          end
        end
      end
      B0:     if (accept) state_next = B1;
      B1:     if (accept) state_next = B2;
      B2:     if (accept) state_next = legal ? WRITE : ERR;
      WRITE:  state_next = more_words ? B0 : DONE;
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The write address and data are captured with the third byte so WRITE can
  // present them directly and they persist after the strobe drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      processor_reset <= 1'b1;
      error           <= 1'b0;
      len_lo          <= '0;
      n               <= '0;
      counter         <= '0;
      code_addr       <= '0;
      code_din        <= '0;
    end else begin
      if (state == IDLE && load_start) begin
        processor_reset <= 1'b1;
        error           <= 1'b0;
      end
      if (state == DONE) begin
        processor_reset <= 1'b0;
      end
      if (state_next == ERR) begin
        error <= 1'b1;
      end
      if (state == LEN_LO && accept) begin
        len_lo <= rx_data;
      end
      if (state == LEN_HI && accept) begin
        n       <= len_rx;
        counter <= '0;
      end
      if (state == B2 && accept && legal) begin
        code_addr <= ADDR_SIZE'(counter);
        code_din  <= WORD_SIZE'(word);
      end
      if (state == WRITE) begin
        counter <= count_inc[15:0];
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: directed streams plus randomized sessions
// scored against a byte-stream reference model.
module tb_code_loader;

  localparam int MEM = 1024;

  typedef int iq_t[$];

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        code_we;
  logic [17:0] code_addr;
  logic [17:0] code_din;
  logic        processor_reset;
  logic        busy;
  logic        error;

  int tests = 0;
  int fails = 0;
  int got_addr[$];
  int got_data[$];
  int exp_addr[$];
  int exp_data[$];
  int ready_in_write = 0;

  always #5 clock = ~clock;

  code_loader #(
    .ADDR_SIZE (18),
    .WORD_SIZE (18),
    .MEM_SIZE  (MEM)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .load_start      (load_start),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .code_we         (code_we),
    .code_addr       (code_addr),
    .code_din        (code_din),
    .processor_reset (processor_reset),
    .busy            (busy),
    .error           (error)
  );

  always @(negedge clock) begin
    if (code_we === 1'b1) begin
      got_addr.push_back(int'(code_addr));
      got_data.push_back(int'(code_din));
      if (rx_ready !== 1'b0) ready_in_write++;
    end
  end

  // Reference: interpret the stream directly; returns 1 when the session must abort.
  function automatic bit model(input iq_t s);
    int n;
    exp_addr.delete();
    exp_data.delete();
    if (s.size() < 2) return 1'b1;
    n = s[0] + 256 * s[1];
    if (n == 0) return 1'b0;
    if (n > MEM) return 1'b1;
    for (int w = 0; w < n; w++) begin
      int p;
      p = 2 + 3 * w;
      if (p + 2 >= s.size()) return 1'b1;
      if (s[p+2] > 3) return 1'b1;
      exp_addr.push_back(w);
      exp_data.push_back(s[p] + 256 * s[p+1] + 65536 * s[p+2]);
    end
    return 1'b0;
  endfunction

  function automatic iq_t gen(input int nw, input bit allow_bad);
    iq_t s;
    int  b2;
    s.push_back(nw % 256);
    s.push_back(nw / 256);
    for (int w = 0; w < nw; w++) begin
      s.push_back(int'($urandom_range(0, 255)));
      s.push_back(int'($urandom_range(0, 255)));
      if (allow_bad && $urandom_range(0, 5) == 0) b2 = int'($urandom_range(4, 255));
      else b2 = int'($urandom_range(0, 3));
      s.push_back(b2);
      if (b2 > 3) break;
    end
    return s;
  endfunction

  task automatic start_load();
    got_addr.delete();
    got_data.delete();
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Offers the bytes in order; the last one transfers on the posedge after return.
  task automatic send_stream(input iq_t s, input bit rand_valid, input int ls_at);
    int idx = 0;
    int guard = 0;
    bit pulsed = 1'b0;
    while (idx < s.size() && guard < 4000) begin
      @(negedge clock);
      guard++;
      rx_data    = 8'(s[idx]);
      rx_valid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      load_start = (ls_at >= 0) && !pulsed && (idx == ls_at);
      if (load_start) pulsed = 1'b1;
      if (rx_valid && rx_ready) idx++;
    end
    if (idx < s.size()) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout: sent %0d bytes, required %0d", idx, s.size());
    end
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    @(negedge clock);
    rx_valid   = 1'b0;
    load_start = 1'b0;
    while (busy !== 1'b0 && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({processor_reset, busy, error, code_we, rx_ready} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags: pr/busy/err/we/rdy=%b required 10000",
               {processor_reset, busy, error, code_we, rx_ready});
    end
    tests++;
    if (code_addr !== '0 || code_din !== '0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h din=%h required 0/0", code_addr, code_din);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    iq_t s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h03};
    start_load();
    send_stream(s, 1'b0, -1);
    @(negedge clock);
    rx_valid = 1'b0;
    tests++;
    if (code_we !== 1'b1 || code_addr !== 18'd1 || code_din !== 18'h3FFFF) begin
      fails++;
      $display("FAIL basic_latency: we=%b addr=%h din=%h required 1/1/3ffff", code_we, code_addr, code_din);
    end
    tests++;
    if (processor_reset !== 1'b1) begin
      fails++;
      $display("FAIL basic_pr_write: pr=%b required 1", processor_reset);
    end
    @(negedge clock);
    tests++;
    if (processor_reset !== 1'b1 || busy !== 1'b1 || code_we !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: pr=%b busy=%b we=%b required 1/1/0", processor_reset, busy, code_we);
    end
    @(negedge clock);
    tests++;
    if (processor_reset !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL basic_release: pr=%b busy=%b err=%b required 0/0/0", processor_reset, busy, error);
    end
    tests++;
    if (got_addr.size() != 2) begin
      fails++;
      $display("FAIL basic_write_count: got %0d required 2", got_addr.size());
    end else begin
      tests++;
      if (got_addr[0] != 0 || got_data[0] != 'h11234) begin
        fails++;
        $display("FAIL basic_word0: addr=%0d data=%h required 0/11234", got_addr[0], got_data[0]);
      end
      tests++;
      if (got_addr[1] != 1 || got_data[1] != 'h3FFFF) begin
        fails++;
        $display("FAIL basic_word1: addr=%0d data=%h required 1/3ffff", got_addr[1], got_data[1]);
      end
    end
  endtask

  task automatic test_zero_len();
    iq_t s = '{8'h00, 8'h00};
    start_load();
    tests++;
    if (processor_reset !== 1'b1) begin
      fails++;
      $display("FAIL zero_pr_raise: pr=%b required 1", processor_reset);
    end
    send_stream(s, 1'b0, -1);
    @(negedge clock);
    rx_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || processor_reset !== 1'b1) begin
      fails++;
      $display("FAIL zero_done: busy=%b pr=%b required 1/1", busy, processor_reset);
    end
    @(negedge clock);
    tests++;
    if (processor_reset !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL zero_release: pr=%b busy=%b err=%b required 0/0/0", processor_reset, busy, error);
    end
    tests++;
    if (got_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_writes: got %0d required 0", got_addr.size());
    end
  endtask

  task automatic test_too_long();
    iq_t s = '{8'h01, 8'h04};
    start_load();
    send_stream(s, 1'b0, -1);
    @(negedge clock);
    rx_valid = 1'b0;
    tests++;
    if (error !== 1'b1 || processor_reset !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL long_err_state: err=%b pr=%b busy=%b required 1/1/1", error, processor_reset, busy);
    end
    repeat (3) @(negedge clock);
    tests++;
    if (error !== 1'b1 || processor_reset !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL long_after: err=%b pr=%b busy=%b required 1/1/0", error, processor_reset, busy);
    end
    tests++;
    if (got_addr.size() != 0) begin
      fails++;
      $display("FAIL long_writes: got %0d required 0", got_addr.size());
    end
  endtask

  task automatic test_bad_b2();
    iq_t s = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h03, 8'h55, 8'h66, 8'h04};
    start_load();
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL bad_err_clear: err=%b required 0", error);
    end
    send_stream(s, 1'b0, -1);
    wait_idle("bad");
    tests++;
    if (error !== 1'b1 || processor_reset !== 1'b1) begin
      fails++;
      $display("FAIL bad_flags: err=%b pr=%b required 1/1", error, processor_reset);
    end
    tests++;
    if (got_addr.size() != 1) begin
      fails++;
      $display("FAIL bad_write_count: got %0d required 1", got_addr.size());
    end else begin
      tests++;
      if (got_addr[0] != 0 || got_data[0] != 'h32211) begin
        fails++;
        $display("FAIL bad_word0: addr=%0d data=%h required 0/32211", got_addr[0], got_data[0]);
      end
    end
  endtask

  task automatic test_random_valid();
    ready_in_write = 0;
    for (int sess = 0; sess < 5; sess++) begin
      iq_t s;
      bit  exp_err;
      s = gen((sess == 0) ? 3 : int'($urandom_range(1, 6)), sess != 0);
      exp_err = model(s);
      start_load();
      tests++;
      if (error !== 1'b0 || processor_reset !== 1'b1) begin
        fails++;
        $display("FAIL rand%0d_start: err=%b pr=%b required 0/1", sess, error, processor_reset);
      end
      send_stream(s, 1'b1, (sess == 0) ? 5 : -1);
      wait_idle("rand");
      tests++;
      if (error !== exp_err || processor_reset !== exp_err) begin
        fails++;
        $display("FAIL rand%0d_flags: err=%b pr=%b required %b/%b", sess, error, processor_reset, exp_err, exp_err);
      end
      tests++;
      if (got_addr.size() != exp_addr.size()) begin
        fails++;
        $display("FAIL rand%0d_count: got %0d required %0d", sess, got_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          tests++;
          if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) begin
            fails++;
            $display("FAIL rand%0d_word%0d: addr=%0d data=%h required %0d/%h",
                     sess, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
    end
    tests++;
    if (ready_in_write != 0) begin
      fails++;
      $display("FAIL ready_in_write: seen %0d times required 0", ready_in_write);
    end
  endtask

  task automatic test_async_reset();
    iq_t part = '{8'h02, 8'h00, 8'hA5, 8'h5A, 8'h02, 8'h11, 8'h22};
    iq_t s;
    bit  exp_err;
    start_load();
    send_stream(part, 1'b0, -1);
    @(negedge clock);
    rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({processor_reset, busy, error, code_we, rx_ready} !== 5'b10000) begin
      fails++;
      $display("FAIL async_flags: pr/busy/err/we/rdy=%b required 10000",
               {processor_reset, busy, error, code_we, rx_ready});
    end
    tests++;
    if (code_addr !== '0 || code_din !== '0) begin
      fails++;
      $display("FAIL async_bus: addr=%h din=%h required 0/0", code_addr, code_din);
    end
    tests++;
    if (got_addr.size() != 1 || got_data[0] != 'h25AA5) begin
      fails++;
      $display("FAIL async_kept: count=%0d required 1 with data 25aa5", got_addr.size());
    end
    @(negedge clock);
    reset = 1'b0;
    s = gen(4, 1'b0);
    exp_err = model(s);
    start_load();
    send_stream(s, 1'b0, -1);
    wait_idle("after_reset");
    tests++;
    if (error !== exp_err || processor_reset !== exp_err) begin
      fails++;
      $display("FAIL after_reset_flags: err=%b pr=%b required %b/%b", error, processor_reset, exp_err, exp_err);
    end
    tests++;
    if (got_addr.size() != exp_addr.size()) begin
      fails++;
      $display("FAIL after_reset_count: got %0d required %0d", got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        tests++;
        if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) begin
          fails++;
          $display("FAIL after_reset_word%0d: addr=%0d data=%h required %0d/%h",
                   i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_bad_b2();
    test_random_valid();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
